// File: rtl/rael.sv
// ============================================================================
//  Module   : rael
//  Purpose  : Registered 8-to-32-bit arithmetic stage: load, accumulate,
//             square or shift-in a byte operand each clock.
//  Options  : RAEL_SAT_EN - accumulate saturates at 32'hFFFFFFFF instead
//             of wrapping modulo 2^32.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rael (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ontiveros,
    input  logic [1:0]  rami,
    output logic [31:0] Y
);

    localparam logic [1:0] C_MODE_LOAD  = 2'b00;
    localparam logic [1:0] C_MODE_ACC   = 2'b01;
    localparam logic [1:0] C_MODE_SQR   = 2'b10;
    localparam logic [1:0] C_MODE_SHIFT = 2'b11;

    logic [31:0] y_q;
    logic [31:0] y_d;
    logic [31:0] acc_w;
    logic [15:0] sqr_w;

`ifdef RAEL_SAT_EN
    logic [32:0] acc_full_w;

    // The carry out of the 33-bit sum flags an overflow; clamp to all-ones.
    always_comb begin
        acc_full_w = {1'b0, y_q} + {25'h0, ontiveros};
        acc_w      = acc_full_w[32] ? 32'hFFFF_FFFF : acc_full_w[31:0];
    end
`else
    always_comb begin
        acc_w = y_q + {24'h0, ontiveros};
    end
`endif

    always_comb begin
        sqr_w = {8'h0, ontiveros} * {8'h0, ontiveros};
    end

    always_comb begin
        y_d = y_q;
        case (rami)
            C_MODE_LOAD:  y_d = {24'h0, ontiveros};
            C_MODE_ACC:   y_d = acc_w;
            C_MODE_SQR:   y_d = {16'h0, sqr_w};
            C_MODE_SHIFT: y_d = {y_q[23:0], ontiveros};
            default:      y_d = y_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 32'h0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

`default_nettype wire

// File: tb/tb_rael.sv
// ============================================================================
//  Module   : tb_rael
//  Purpose  : Self-checking bench for rael: directed sweeps plus randomized
//             operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rael;

    logic        clk;
    logic        rst;
    logic [7:0]  ontiveros;
    logic [1:0]  rami;
    logic [31:0] Y;

    int unsigned n_vec;
    int unsigned n_err;
    longint      exp_y;

    rael u_dut (
        .clk       (clk),
        .rst       (rst),
        .ontiveros (ontiveros),
        .rami      (rami),
        .Y         (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: Y=%08h expected %08h", tag, got, want);
        end
    endtask

    // Reference model: mode semantics computed with plain 64-bit arithmetic.
    task automatic model_step(input logic [1:0] m, input logic [7:0] b);
        longint s;
        case (m)
            2'b00: exp_y = longint'(b);
            2'b01: begin
                s = exp_y + longint'(b);
`ifdef RAEL_SAT_EN
                exp_y = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
`else
                exp_y = s % 64'h1_0000_0000;
`endif
            end
            2'b10: exp_y = longint'(b) * longint'(b);
            default: exp_y = (exp_y * 256 + longint'(b)) % 64'h1_0000_0000;
        endcase
    endtask

    // Inputs change 1 ns after a rising edge; Y is sampled 1 ns after the next.
    task automatic apply(input string tag, input logic [1:0] m, input logic [7:0] b);
        rami      = m;
        ontiveros = b;
        @(posedge clk);
        #1;
        model_step(m, b);
        chk_eq(tag, Y, exp_y[31:0]);
    endtask

    // Pulse rst between edges and confirm Y clears before any clock edge.
    task automatic pulse_rst(input string tag);
        #2;
        rst = 1'b1;
        #1;
        exp_y = 0;
        chk_eq(tag, Y, 32'h0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] m;
        logic [7:0] b;
        n_vec     = 0;
        n_err     = 0;
        exp_y     = 0;
        rst       = 1'b0;
        rami      = 2'b00;
        ontiveros = 8'h0;

        #1 rst = 1'b1;
        #2 chk_eq("reset_async", Y, 32'h0);
        @(posedge clk);
        #1 chk_eq("reset_held", Y, 32'h0);
        #1 rst = 1'b0;

        for (int i = 0; i <= 10; i++) apply("load_sweep", 2'b00, 8'(i));
        chk_eq("load_final", Y, 32'd10);

        for (int i = 11; i <= 20; i++) apply("square_sweep", 2'b10, 8'(i));
        chk_eq("square_400", Y, 32'd400);
        apply("square_255", 2'b10, 8'hFF);
        chk_eq("square_max", Y, 32'h0000_FE01);

        apply("shift", 2'b11, 8'h12);
        apply("shift", 2'b11, 8'h34);
        apply("shift", 2'b11, 8'h56);
        apply("shift", 2'b11, 8'h78);
        chk_eq("shift_pack", Y, 32'h1234_5678);
        apply("shift", 2'b11, 8'h9A);
        chk_eq("shift_fifth", Y, 32'h3456_789A);

        apply("acc_clear", 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) apply("acc_255", 2'b01, 8'hFF);
        chk_eq("acc_1020", Y, 32'd1020);

        apply("preload", 2'b11, 8'hFF);
        apply("preload", 2'b11, 8'hFF);
        apply("preload", 2'b11, 8'hFF);
        apply("preload", 2'b11, 8'hF0);
        chk_eq("preload_val", Y, 32'hFFFF_FFF0);
        apply("acc_ovf", 2'b01, 8'h20);
`ifdef RAEL_SAT_EN
        chk_eq("acc_ovf_sat", Y, 32'hFFFF_FFFF);
        apply("acc_sat_hold", 2'b01, 8'h01);
        chk_eq("acc_sat_stay", Y, 32'hFFFF_FFFF);
`else
        chk_eq("acc_ovf_wrap", Y, 32'h0000_0010);
`endif

        apply("mid_load", 2'b00, 8'h00);
        apply("mid_acc", 2'b01, 8'h05);
        apply("mid_acc", 2'b01, 8'h05);
        pulse_rst("reset_mid_acc");
        apply("post_reset_acc", 2'b01, 8'h05);
        chk_eq("post_reset_5", Y, 32'd5);

        apply("switch_load", 2'b00, 8'd7);
        apply("switch_acc", 2'b01, 8'd3);
        chk_eq("switch_10", Y, 32'd10);

        for (int i = 0; i < 400; i++) begin
            m = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            apply("random", m, b);
            if ($urandom_range(0, 49) == 0) pulse_rst("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
